// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, FSM states and op-classification helpers for mult_div_unit.
// Optional MDU_MADD_EN enables the madd/maddu/msub/msubu accumulate ops.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MTHI  = 4'd5,
    MD_OP_MTLO  = 4'd6,
    MD_OP_MADD  = 4'd7,
    MD_OP_MADDU = 4'd8,
    MD_OP_MSUB  = 4'd9,
    MD_OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_INT_MIN  = 32'h8000_0000;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic md_op_is_long(input logic [3:0] op);
    case (op)
      MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: md_op_is_long = 1'b1;
`ifdef MDU_MADD_EN
      MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: md_op_is_long = 1'b1;
`endif
      default: md_op_is_long = 1'b0;
    endcase
  endfunction

  function automatic logic md_op_is_div(input logic [3:0] op);
    case (op)
      MD_OP_DIV, MD_OP_DIVU: md_op_is_div = 1'b1;
      default:               md_op_is_div = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational HI/LO result generator: multiply, divide and (with MDU_MADD_EN)
// multiply-accumulate against the current HI/LO pair.
module mult_div_unit_arith
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic        div_signed_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] mag_b_safe_s;
  logic [31:0] mag_q_s;
  logic [31:0] mag_r_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
`ifdef MDU_MADD_EN
  logic [63:0] acc_s;
`endif

  // Products and sign-magnitude division shared by all ops.
  always_comb begin
    prod_s_s     = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    prod_u_s     = {32'd0, op_a} * {32'd0, op_b};
    div_signed_s = (op == MD_OP_DIV);
    neg_a_s      = div_signed_s & op_a[31];
    neg_b_s      = div_signed_s & op_b[31];
    mag_a_s      = neg_a_s ? (32'd0 - op_a) : op_a;
    mag_b_s      = neg_b_s ? (32'd0 - op_b) : op_b;
    // Keep the divider X-free on a zero divisor; that case is overridden below.
    mag_b_safe_s = (op_b == 32'd0) ? 32'd1 : mag_b_s;
    mag_q_s      = mag_a_s / mag_b_safe_s;
    mag_r_s      = mag_a_s % mag_b_safe_s;
    quo_s        = (neg_a_s ^ neg_b_s) ? (32'd0 - mag_q_s) : mag_q_s;
    rem_s        = neg_a_s ? (32'd0 - mag_r_s) : mag_r_s;
  end

  // Per-op result selection.
  always_comb begin
`ifdef MDU_MADD_EN
    acc_s = {cur_hi, cur_lo};
`endif
    {res_hi, res_lo} = {cur_hi, cur_lo};
    case (op)
      MD_OP_MULT:  {res_hi, res_lo} = prod_s_s;
      MD_OP_MULTU: {res_hi, res_lo} = prod_u_s;
      MD_OP_DIV, MD_OP_DIVU: begin
        if (op_b == 32'd0) begin
          {res_hi, res_lo} = {op_a, MD_ALL_ONES};
        end else if (div_signed_s && (op_a == MD_INT_MIN) && (op_b == MD_ALL_ONES)) begin
          {res_hi, res_lo} = {32'd0, MD_INT_MIN};
        end else begin
          {res_hi, res_lo} = {rem_s, quo_s};
        end
      end
`ifdef MDU_MADD_EN
      MD_OP_MADD:  {res_hi, res_lo} = acc_s + prod_s_s;
      MD_OP_MADDU: {res_hi, res_lo} = acc_s + prod_u_s;
      MD_OP_MSUB:  {res_hi, res_lo} = acc_s - prod_s_s;
      MD_OP_MSUBU: {res_hi, res_lo} = acc_s - prod_u_s;
`endif
      default:     {res_hi, res_lo} = {cur_hi, cur_lo};
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; models fixed latencies with a
// countdown and exposes busy/done. MDU_MADD_EN enables the accumulate ops.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] arith_hi_s;
  logic [31:0] arith_lo_s;

  mult_div_unit_arith u_arith (
    .op     (mdOp),
    .op_a   (operandA),
    .op_b   (operandB),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (arith_hi_s),
    .res_lo (arith_lo_s)
  );

  // Next-state: accept in IDLE, count down and commit in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          if (mdOp == MD_OP_MTHI) begin
            hi_d = operandA;
          end else if (mdOp == MD_OP_MTLO) begin
            lo_d = operandA;
          end else if (md_op_is_long(mdOp)) begin
            pend_hi_d = arith_hi_s;
            pend_lo_d = arith_lo_s;
            cnt_d     = md_op_is_div(mdOp) ? DIV_LAT : MULT_LAT;
            state_d   = ST_RUN;
            busy_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit owning the HI/LO register pair for the pipelined MIPS core. It sits in the E stage beside the ALU and accepts one operation per start pulse. It models the fixed multiply and divide latencies with an internal countdown and exposes `busy`, so the hazard logic can stall D-stage `mfhi`/`mflo` and any further multiply/divide instruction until results are committed.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd family), legal range 1..31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu, legal range 1..31.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: E-stage valid request; sampled on the rising edge.
- `mdOp` in 4: operation code (`mdOp*` constants, below).
- `operandA` in 32: rs value, already forwarded.
- `operandB` in 32: rt value, already forwarded.
- `busy` out 1: registered; high while an operation is pending.
- `done` out 1: registered one-cycle pulse in the cycle new HI/LO first become visible.
- `hi` out 32: current HI.
- `lo` out 32: current LO.

## Operation
- Op codes: `mdOpNone`=0, `mdOpMult`=1, `mdOpMultu`=2, `mdOpDiv`=3, `mdOpDivu`=4, `mdOpMthi`=5, `mdOpMtlo`=6, `mdOpMadd`=7, `mdOpMaddu`=8, `mdOpMsub`=9, `mdOpMsubu`=10. Other codes behave as `mdOpNone`.
- States: IDLE and RUN.
- An operation is accepted when `start` is high, `busy` is low, and the op is not None.
- In IDLE, mthi/mtlo write `operandA` to HI/LO on the accepting edge. There is no RUN and no `done`.
- In IDLE, mult/div ops do three things on the accepting edge: compute the result into `pendHi`/`pendLo`, load the counter with the op's latency, and enter RUN.
- In RUN:
  - The counter decrements each edge.
  - On the edge where the counter goes from 1 to 0, HI/LO take `pendHi`/`pendLo`, `done` is set for one cycle, and the state returns to IDLE.
- While `busy` is high, `start` is ignored, including mthi/mtlo. The hazard unit guarantees this never happens; the bench still checks that HI/LO are unaffected.
- Arithmetic:
  - mult gives a signed 64-bit product; multu gives an unsigned one. HI = [63:32], LO = [31:0].
  - div/divu: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = `operandA`.
  - Signed overflow, 0x80000000 / -1: LO = 0x80000000, HI = 0.
  - madd/msub: {HI,LO} ± product modulo 2^64. {HI,LO} is sampled at the accepting edge.
- `reset` asynchronously sets HI = LO = 0, `busy` = 0, `done` = 0, and the state to IDLE. A reset during RUN discards the pending results.

## Timing
- Start accepted at edge T:
  - `busy` is high from T through T+N−1 (N = latency).
  - At edge T+N: HI/LO update, `busy` falls, `done` pulses for one cycle.
- `busy` is high for exactly N cycles. A new start is accepted at edge T+N, the same edge `busy` drops is not usable because `busy` is sampled high before it; the first accepting edge is T+N+1.
- mthi/mtlo take effect at the accepting edge and are visible the next cycle.
- The hazard unit must stall a D-stage `mfhi`/`mflo`/md op whenever `busy` is high, or when `start` is high with a multi-cycle op.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MDU_MADD_EN` defined: madd/maddu/msub/msubu are supported with latency `MULT_CYCLES`.
- `MDU_MADD_EN` undefined: op codes 7..10 are treated as `mdOpNone`. They are never accepted, leave HI/LO unchanged, and never set `busy`. The accumulate adder is not synthesized.

## Structure
- The `mdOp*` codes and their 4-bit width go in the shared `constants.v`, next to the `alu*`/`grfWrite*` defines.
- The Controller decodes mult/div/mfhi/mflo/mthi/mtlo into `mdOp`. This block does not decode instructions.
- One sub-module is natural: `mdu_arith`, a combinational unit computing {hi,lo} from op, operands and the current {HI,LO}. `mult_div_unit` holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset, then `mult` with 0xFFFFFFFE × 3 → `busy` is high for 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA, with one `done` pulse.
- `divu` with 7 / 0 → after 10 cycles, LO = 0xFFFFFFFF, HI = 7. Then `div` with −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- `mthi` 0x1234 while idle → HI = 0x1234 the next cycle, `busy` stays 0. `mtlo` issued while a `mult` is in RUN → ignored; LO takes the mult result.
- `div` with 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. Back-to-back: a second `start` held high through `busy` is accepted at T+N+1.
- Reset asserted in the 3rd RUN cycle of a `mult` → HI = LO = 0 and `busy` = 0 immediately, and no `done` pulse.
- With `MDU_MADD_EN`: HI:LO = 0:0xFFFFFFFF, then `maddu` 1 × 1 → HI = 1, LO = 0. Without it, the same op leaves HI/LO unchanged and `busy` = 0.
